spi_shift_engine: RTL and testbench

- Serial transfer engine between the SPI TX FIFO output and the RX FIFO input of the SPI peripheral.
- Pops one word from the TX FIFO, frames it with chip select, and shifts it out MSB-first on spi_tx at a programmable SCLK rate in any of the four SPI modes.
- Captures spi_rx in parallel and pushes the received word into the RX FIFO.
- Replaces the ad-hoc serializer in the register block; control/brd fields are wired straight in.

---
 rtl/spi_shift_engine_if.sv | 31 +++
 rtl/spi_shift_engine.sv | 200 ++++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_shift_engine_if.sv
// FIFO-side bundle of the SPI shift engine: TX FIFO head/pop and RX FIFO push.
// master = engine side, slave = FIFO side.
interface spi_shift_engine_if;
  logic        tx_empty;
  logic [31:0] tx_data;
  logic        tx_pop;
  logic        rx_full;
  logic [31:0] rx_data;
  logic        rx_push;
  logic        rx_drop;

  modport master (
    input  tx_empty,
    input  tx_data,
    input  rx_full,
    output tx_pop,
    output rx_data,
    output rx_push,
    output rx_drop
  );

  modport slave (
    output tx_empty,
    output tx_data,
    output rx_full,
    input  tx_pop,
    input  rx_data,
    input  rx_push,
    input  rx_drop
  );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI shift engine: pops TX words, frames CS, shifts MSB-first in any mode, pushes RX.
// Ports: clk/reset(sync, low), control, fifo bundle, spi_clk/tx/rx, spi_cs0..3, busy.
module spi_shift_engine #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [4:0]       word_size,
  input  logic [1:0]       mode,
  input  logic [1:0]       cs_select,
  input  logic [3:0]       cs_auto,
  input  logic [3:0]       cs_enable,
  input  logic [DIV_W-1:0] brd,
  spi_shift_engine_if.master fifo,
  output logic             spi_clk,
  output logic             spi_tx,
  input  logic             spi_rx,
  output logic             spi_cs0,
  output logic             spi_cs1,
  output logic             spi_cs2,
  output logic             spi_cs3,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] brd_m1;
  logic             tick;

  logic [31:0] data_q;
  logic [31:0] rx_sr;
  logic [4:0]  ws_q;
  logic        cpol_q;
  logic        cpha_q;
  logic [1:0]  sel_q;
  logic [1:0]  sel_nx;
  logic [5:0]  edge_cnt;

  logic        pop;
  logic        last_edge;
  logic        lead;
  logic        sample;
  logic        drv;
  logic [4:0]  j;
  logic [4:0]  drv_idx;
  logic [3:0]  cs_q;
  logic [3:0]  cs_nx;

  assign brd_m1 = (brd == '0) ? '0
                : brd - DIV_W'(1);
  assign tick   = (state != IDLE) &&
                  (cnt >= brd_m1);

  // edge_cnt counts SCLK edges already made;
  // even = leading edge, pair index in j
  assign last_edge = edge_cnt == {ws_q, 1'b1};
  assign lead      = ~edge_cnt[0];
  assign j         = edge_cnt[5:1];
  assign sample    = lead ^ cpha_q;

  always_comb begin
    drv     = 1'b0;
    drv_idx = '0;
    if (cpha_q) begin
      drv     = lead;
      drv_idx = ws_q - j;
    end else begin
      drv     = !lead && (j != ws_q);
      drv_idx = ws_q - j - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == IDLE) begin
      if (enable && !fifo.tx_empty)
        state_nx = SETUP;
    end else if (!enable) begin
      state_nx = IDLE;
    end else if (tick) begin
      unique case (state)
        SETUP:   state_nx = SHIFT;
        SHIFT:   if (last_edge)
                   state_nx = HOLD;
        HOLD:    state_nx = GAP;
        GAP:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    pop = reset && (state == IDLE) &&
          enable && !fifo.tx_empty;
    sel_nx = pop ? cs_select : sel_q;
    for (int i = 0; i < 4; i++) begin
      cs_nx[i] = 1'b1;
      if (!cs_auto[i])
        cs_nx[i] = ~cs_enable[i];
      else if (sel_nx == 2'(i) &&
               (state_nx == SETUP ||
                state_nx == SHIFT ||
                state_nx == HOLD))
        cs_nx[i] = 1'b0;
    end
  end

  assign fifo.tx_pop = pop;
  assign busy        = state != IDLE;
  assign spi_cs0     = cs_q[0];
  assign spi_cs1     = cs_q[1];
  assign spi_cs2     = cs_q[2];
  assign spi_cs3     = cs_q[3];

  // divider restarts on every state entry
  always_ff @(posedge clk) begin
    if (!reset)
      cnt <= '0;
    else if (state == IDLE || tick ||
             state_nx != state)
      cnt <= '0;
    else
      cnt <= cnt + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      spi_clk      <= 1'b0;
      spi_tx       <= 1'b0;
      cs_q         <= 4'hF;
      fifo.rx_push <= 1'b0;
      fifo.rx_drop <= 1'b0;
      fifo.rx_data <= '0;
      data_q       <= '0;
      rx_sr        <= '0;
      ws_q         <= '0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      sel_q        <= '0;
      edge_cnt     <= '0;
    end else begin
      cs_q         <= cs_nx;
      fifo.rx_push <= 1'b0;
      fifo.rx_drop <= 1'b0;
      if (state == IDLE) begin
        spi_clk <= mode[1];
        spi_tx  <= 1'b0;
        if (pop) begin
          data_q   <= fifo.tx_data;
          ws_q     <= word_size;
          cpol_q   <= mode[1];
          cpha_q   <= mode[0];
          sel_q    <= cs_select;
          edge_cnt <= '0;
          rx_sr    <= '0;
          spi_tx   <= !mode[0] &&
                      fifo.tx_data[word_size];
        end
      end else if (!enable) begin
        spi_clk <= cpol_q;
        spi_tx  <= 1'b0;
      end else if (tick) begin
        if (state == SHIFT) begin
          spi_clk  <= ~spi_clk;
          edge_cnt <= edge_cnt + 6'd1;
          if (drv)
            spi_tx <= data_q[drv_idx];
          if (sample)
            rx_sr <= {rx_sr[30:0], spi_rx};
        end
        if (state == HOLD) begin
          spi_tx <= 1'b0;
          if (!fifo.rx_full) begin
            fifo.rx_push <= 1'b1;
            fifo.rx_data <= rx_sr;
          end else begin
            fifo.rx_drop <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: timeline model, directed and random words.
// Drives config, FIFO bundle and MISO (loopback or constant level).
module tb_spi_shift_engine;
  localparam int DIV_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [4:0] word_size;
  logic [1:0] mode;
  logic [1:0] cs_select;
  logic [3:0] cs_auto;
  logic [3:0] cs_enable;
  logic [DIV_W-1:0] brd;
  logic spi_clk, spi_tx, spi_rx, busy;
  logic spi_cs0, spi_cs1, spi_cs2, spi_cs3;
  logic loop_rx, rx_level;

  spi_shift_engine_if fif ();

  assign spi_rx = loop_rx ? spi_tx : rx_level;

  always #5 clk = ~clk;

  spi_shift_engine #(.DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .word_size(word_size), .mode(mode),
    .cs_select(cs_select), .cs_auto(cs_auto),
    .cs_enable(cs_enable), .brd(brd),
    .fifo(fif),
    .spi_clk(spi_clk), .spi_tx(spi_tx),
    .spi_rx(spi_rx),
    .spi_cs0(spi_cs0), .spi_cs1(spi_cs1),
    .spi_cs2(spi_cs2), .spi_cs3(spi_cs3),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  logic [31:0] txq[$];

  // model state: one word described by its pop-relative cycle index d
  bit          valid = 0;
  bit          active = 0;
  bit          pop_pending = 0;
  int          d, b, nb;
  logic [4:0]  ws;
  logic [31:0] wdata, exp_word;
  logic        cpol, cpha, idle_clk;
  logic [1:0]  sel;
  logic        e_clk, e_tx, e_busy, e_push, e_drop;
  logic [31:0] e_rxd;
  logic [3:0]  e_cs;

  task automatic wave(input int dd,
                      output logic c,
                      output logic t);
    int e, sh;
    sh = 2 * nb * b;
    if (dd <= b) begin
      c = cpol;
      t = cpha ? 1'b0 : wdata[ws];
    end else if (dd <= b + sh) begin
      e = (dd - 1) / b - 1;
      c = cpol ^ e[0];
      if (cpha)
        t = (e == 0) ? 1'b0
          : wdata[int'(ws) - (e - 1) / 2];
      else
        t = wdata[int'(ws) - e / 2];
    end else if (dd <= 2 * b + sh) begin
      c = cpol;
      t = wdata[0];
    end else begin
      c = cpol;
      t = 1'b0;
    end
  endtask

  initial begin : model
    logic [31:0] junk, mask;
    bit exp_pop;
    int sh;
    fif.tx_empty = 1'b1;
    fif.tx_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pop_pending) begin
        junk = txq.pop_front();
        pop_pending = 0;
      end
      fif.tx_empty = (txq.size() == 0);
      fif.tx_data  = fif.tx_empty ? 32'h0 : txq[0];
      @(negedge clk);
      exp_pop = reset && !active && enable &&
                !fif.tx_empty;
      if (valid) begin
        chk("tx_pop", 32'(fif.tx_pop), 32'(exp_pop));
        chk("spi_clk", 32'(spi_clk), 32'(e_clk));
        chk("spi_tx", 32'(spi_tx), 32'(e_tx));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("rx_push", 32'(fif.rx_push), 32'(e_push));
        chk("rx_drop", 32'(fif.rx_drop), 32'(e_drop));
        chk("rx_data", fif.rx_data, e_rxd);
        chk("cs", 32'({spi_cs3, spi_cs2, spi_cs1, spi_cs0}),
            32'(e_cs));
      end
      if (!reset) begin
        valid = 1; active = 0;
        e_clk = 0; e_tx = 0; e_cs = 4'hF;
        e_push = 0; e_drop = 0; e_rxd = 0;
        e_busy = 0;
      end else if (valid) begin
        e_push = 0; e_drop = 0;
        if (active) begin
          sh = 2 * nb * b;
          if (!enable || d == 3 * b + sh) begin
            active = 0;
            idle_clk = cpol;
          end else begin
            if (d == 2 * b + sh) begin
              if (fif.rx_full) e_drop = 1;
              else begin
                e_push = 1;
                e_rxd = exp_word;
              end
            end
            d++;
          end
        end else begin
          idle_clk = mode[1];
          if (exp_pop) begin
            active = 1; d = 1; pop_pending = 1;
            b  = (brd == 0) ? 1 : int'(brd);
            ws = word_size;
            nb = int'(word_size) + 1;
            wdata = fif.tx_data;
            cpol = mode[1]; cpha = mode[0];
            sel = cs_select;
            mask = (nb == 32) ? 32'hFFFF_FFFF
                 : ((32'd1 << nb) - 32'd1);
            exp_word = loop_rx ? (wdata & mask)
                     : (rx_level ? mask : 32'h0);
          end
        end
        if (active) wave(d, e_clk, e_tx);
        else begin
          e_clk = idle_clk;
          e_tx = 0;
        end
        sh = 2 * nb * b;
        for (int i = 0; i < 4; i++)
          e_cs[i] = !cs_auto[i] ? ~cs_enable[i]
                  : !(active && sel == 2'(i) &&
                      d <= 2 * b + sh);
        e_busy = active;
      end
    end
  end

  // observed-event recorder for the directed checks
  logic [31:0] push_q[$];
  int drop_n = 0, pop_n = 0, rise_n = 0;
  int fall_n = 0, cs0_low_n = 0;
  logic [63:0] rise_bits = '0;
  logic prev_clk = 1'b0;

  always @(negedge clk) begin
    if (fif.rx_push === 1'b1)
      push_q.push_back(fif.rx_data);
    if (fif.rx_drop === 1'b1) drop_n++;
    if (fif.tx_pop === 1'b1) pop_n++;
    if (spi_cs0 === 1'b0) cs0_low_n++;
    if (spi_clk === 1'b1 && prev_clk === 1'b0) begin
      rise_n++;
      rise_bits = {rise_bits[62:0], spi_tx};
    end
    if (spi_clk === 1'b0 && prev_clk === 1'b1)
      fall_n++;
    prev_clk = spi_clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm,
                           input int budget);
    int k = 0;
    step(2);
    while (!(!active && txq.size() == 0 &&
             !pop_pending) && k < budget) begin
      step(1);
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, engine still busy",
               nm, k);
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int np, nr, nf, nc, nd;
    reset = 0; enable = 0;
    word_size = 5'd7; mode = 2'd0;
    cs_select = 2'd0; cs_auto = 4'hF;
    cs_enable = 4'h0; brd = 16'd2;
    fif.rx_full = 1'b0;
    loop_rx = 1'b1; rx_level = 1'b0;
    step(3);
    chk("rst_cs", 32'({spi_cs3, spi_cs2, spi_cs1, spi_cs0}),
        32'hF);
    chk("rst_clk", 32'(spi_clk), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rxd", fif.rx_data, 32'h0);
    reset = 1; enable = 1;
    step(2);

    // mode 0, 8 bits, brd 2, loopback
    np = push_q.size(); nr = rise_n; nc = cs0_low_n;
    txq.push_back(32'hA5);
    wait_idle("t1", 500);
    chk("t1_npush", 32'(push_q.size() - np), 32'd1);
    chk("t1_rxd", push_q[push_q.size() - 1], 32'hA5);
    chk("t1_rises", 32'(rise_n - nr), 32'd8);
    chk("t1_bits", 32'(rise_bits[7:0]), 32'hA5);
    chk("t1_cslow", 32'(cs0_low_n - nc), 32'd36);

    // mode 3, 16 bits, brd 1, MISO held high
    mode = 2'd3; word_size = 5'd15; brd = 16'd1;
    loop_rx = 1'b0; rx_level = 1'b1;
    step(2);
    np = push_q.size(); nr = rise_n; nf = fall_n;
    txq.push_back(32'h1234);
    wait_idle("t2", 500);
    chk("t2_rxd", push_q[push_q.size() - 1], 32'hFFFF);
    chk("t2_falls", 32'(fall_n - nf), 32'd16);
    chk("t2_bits", 32'(rise_bits[15:0]), 32'h1234);
    chk("t2_idleclk", 32'(spi_clk), 32'h1);

    // mode 1, two queued words
    mode = 2'd1; word_size = 5'd7; brd = 16'd2;
    loop_rx = 1'b1;
    step(2);
    np = push_q.size(); nd = pop_n;
    txq.push_back(32'h11);
    txq.push_back(32'h22);
    wait_idle("t3", 1000);
    chk("t3_pops", 32'(pop_n - nd), 32'd2);
    chk("t3_npush", 32'(push_q.size() - np), 32'd2);
    chk("t3_first", push_q[np], 32'h11);
    chk("t3_second", push_q[np + 1], 32'h22);

    // RX FIFO full: word dropped, rx_data kept
    fif.rx_full = 1'b1;
    np = push_q.size(); nd = drop_n;
    txq.push_back(32'h5A);
    wait_idle("t4", 500);
    fif.rx_full = 1'b0;
    chk("t4_drop", 32'(drop_n - nd), 32'd1);
    chk("t4_nopush", 32'(push_q.size() - np), 32'd0);
    chk("t4_rxd", fif.rx_data, 32'h22);

    // abort a 32-bit word mid-shift
    mode = 2'd0; word_size = 5'd31; brd = 16'd1;
    step(2);
    np = push_q.size();
    txq.push_back(32'hDEADBEEF);
    step(25);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_cs0", 32'(spi_cs0), 32'h1);
    chk("t5_clk", 32'(spi_clk), 32'h0);
    step(1);
    enable = 1'b1;
    wait_idle("t5a", 100);
    chk("t5_nopush", 32'(push_q.size() - np), 32'd0);
    txq.push_back(32'hCAFE0001);
    wait_idle("t5b", 500);
    chk("t5_rxd", push_q[push_q.size() - 1], 32'hCAFE0001);

    // manual CS, then reset mid-transfer
    cs_auto = 4'h0; cs_enable = 4'b0100;
    word_size = 5'd7; brd = 16'd2;
    step(2);
    chk("t6_cs", 32'({spi_cs3, spi_cs2, spi_cs1, spi_cs0}),
        32'hB);
    txq.push_back(32'h3C);
    step(10);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_rbusy", 32'(busy), 32'h0);
    chk("t6_rclk", 32'(spi_clk), 32'h0);
    chk("t6_rtx", 32'(spi_tx), 32'h0);
    chk("t6_rrxd", fif.rx_data, 32'h0);
    chk("t6_rcs", 32'({spi_cs3, spi_cs2, spi_cs1, spi_cs0}),
        32'hF);
    step(1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_cs2", 32'({spi_cs3, spi_cs2, spi_cs1, spi_cs0}),
        32'hB);
    step(1);
    cs_auto = 4'hF;
    step(2);

    // randomized words; config churn mid-word has no effect
    for (int it = 0; it < 30; it++) begin
      int k, nw;
      brd       = 16'($urandom_range(0, 3));
      word_size = 5'($urandom);
      mode      = 2'($urandom);
      cs_select = 2'($urandom);
      cs_auto   = 4'($urandom) | 4'h1;
      cs_enable = 4'($urandom);
      loop_rx   = 1'($urandom);
      rx_level  = 1'($urandom);
      enable    = 1'b1;
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++)
        txq.push_back($urandom);
      k = 0;
      step(2);
      while (!(!active && txq.size() == 0 &&
               !pop_pending) && k < 3000) begin
        fif.rx_full = ($urandom_range(0, 3) == 0);
        word_size   = 5'($urandom);
        mode        = 2'($urandom);
        cs_select   = 2'($urandom);
        enable      = ($urandom_range(0, 299) != 0);
        step(1);
        k++;
      end
      n_checks++;
      if (k >= 3000) begin
        n_fail++;
        $display("FAIL rand%0d: timeout, engine still busy", it);
      end
      enable = 1'b1;
      fif.rx_full = 1'b0;
      step(2);
    end

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
